// File: rtl/prefetch_pkg.sv
// Shared types for the prefetch scheduler: FSM states, burst bound, buffer entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prefetch_pkg;

    // Largest neighbour burst any grid address can produce (interior point).
    localparam int MAX_NEIGHBORS = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2
    } state_t;

    // Buffer entry layout at the default widths (2-bit id, 32-bit address).
    localparam int ENTRY_ID_W   = 2;
    localparam int ENTRY_ADDR_W = 32;

    typedef struct packed {
        logic [ENTRY_ID_W-1:0]   id;
        logic [ENTRY_ADDR_W-1:0] addr;
    } fifo_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous first-word-fall-through FIFO reporting its free slot count.
// Latency: a push at cycle c is visible at the head at c+1; push and pop may share a cycle.
// Backpressure: pushes when full and pops when empty are ignored; the owner gates on free_o.
module prefetch_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CNT_W-1:0] free_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push   = push_i && (count != CNT_W'(DEPTH));
    assign do_pop    = pop_i && (count != '0);
    assign valid_o   = (count != '0);
    assign pop_dat_o = mem[rd_ptr];
    assign free_o    = CNT_W'(DEPTH) - count;

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_scheduler.sv
// Round-robin arbiter feeding one shared 3-D prefetcher; buffers each neighbour burst tagged with requester id.
// Latency: accept at t, prefetch issue at t+1, collect from t+2; buffered neighbours appear one cycle after capture.
// Backpressure: requests are admitted only with room for a full burst, since the prefetcher cannot be stalled.
module prefetch_scheduler
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int X_DIM      = 4,
    parameter int Y_DIM      = 4,
    parameter int Z_DIM      = 4,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_address_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              pf_valid_o,
    output logic [ADDR_WIDTH-1:0]             pf_address_o,
    input  logic                              pf_ready_i,
    input  logic [ADDR_WIDTH-1:0]             pf_address_i,
    output logic                              mem_valid_o,
    input  logic                              mem_ready_i,
    output logic [ADDR_WIDTH-1:0]             mem_address_o,
    output logic [ID_W-1:0]                   mem_id_o,
    output logic                              busy_o,
    output logic                              timeout_o,
    output logic [7:0]                        drop_cnt_o
);

    localparam int LX     = $clog2(X_DIM);
    localparam int LY     = $clog2(Y_DIM);
    localparam int LZ     = $clog2(Z_DIM);
    localparam int FREE_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam logic [ADDR_WIDTH:0] GRID_SIZE = (ADDR_WIDTH + 1)'(X_DIM * Y_DIM * Z_DIM);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [2:0]          exp_q;
    logic [2:0]          cnt;
    logic [TMR_W-1:0]    tmr;

    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    int                  scan_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                in_range;
    logic [LX-1:0]       x;
    logic [LY-1:0]       y;
    logic [LZ-1:0]       z;
    logic [2:0]          exp_n;
    logic                admit;
    logic                push;
    logic                push_last;
    logic [FREE_W-1:0]   fifo_free;
    entry_t              push_entry;
    entry_t              head;

    // Round-robin pick: first valid requester at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!gnt_found && req_valid_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Decode the granted address and count how many grid neighbours it has.
    always_comb begin
        sel_addr = req_address_i[gnt_idx];
        in_range = ({1'b0, sel_addr} < GRID_SIZE);
        x        = sel_addr[LX-1:0];
        y        = sel_addr[LX+LY-1:LX];
        z        = sel_addr[LX+LY+LZ-1:LX+LY];
        exp_n    = 3'(x != '0) + 3'(x != LX'(X_DIM - 1))
                 + 3'(y != '0) + 3'(y != LY'(Y_DIM - 1))
                 + 3'(z != '0) + 3'(z != LZ'(Z_DIM - 1));
    end

    // Admission needs IDLE and room for the largest possible burst.
    always_comb begin
        admit       = (state == IDLE) && (fifo_free >= FREE_W'(MAX_NEIGHBORS)) && gnt_found;
        req_ready_o = admit ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign push       = (state == COLLECT) && pf_ready_i;
    assign push_last  = push && ((cnt + 3'd1) == exp_q);
    assign push_entry = '{id: id_q, addr: pf_address_i};

    // Sequencer: accept/drop, one-cycle issue, then collect until the burst completes or times out.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_q         <= '0;
            exp_q        <= '0;
            cnt          <= '0;
            tmr          <= '0;
            pf_valid_o   <= 1'b0;
            pf_address_o <= '0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (admit) begin
                        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                        if (in_range) begin
                            state        <= ISSUE;
                            pf_valid_o   <= 1'b1;
                            pf_address_o <= sel_addr;
                            id_q         <= gnt_idx;
                            exp_q        <= exp_n;
                            busy_o       <= 1'b1;
                        end else if (drop_cnt_o != 8'hFF) begin
                            drop_cnt_o <= drop_cnt_o + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    pf_valid_o <= 1'b0;
                    state      <= COLLECT;
                    cnt        <= '0;
                    tmr        <= '0;
                end
                COLLECT: begin
                    if (push) begin
                        cnt <= cnt + 3'd1;
                    end
                    if (push_last) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    prefetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (mem_valid_o && mem_ready_i),
        .valid_o    (mem_valid_o),
        .pop_dat_o  (head),
        .free_o     (fifo_free)
    );

    assign mem_address_o = head.addr;
    assign mem_id_o      = head.id;

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Directed bench for prefetch_scheduler with a behavioural 4x4x4 prefetcher model.
// Latency: model answers two cycles after seeing the issue pulse.
// Backpressure: memory side driven directly by the stimulus sequence.
module tb_prefetch_scheduler;
    import prefetch_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic [3:0]        req_valid_i;
    logic [3:0][31:0]  req_address_i;
    logic [3:0]        req_ready_o;
    logic              pf_valid_o;
    logic [31:0]       pf_address_o;
    logic              pf_ready_i;
    logic [31:0]       pf_address_i;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [31:0]       mem_address_o;
    logic [1:0]        mem_id_o;
    logic              busy_o;
    logic              timeout_o;
    logic [7:0]        drop_cnt_o;

    int vectors    = 0;
    int miscompares = 0;
    int model_limit = 6;
    int busy_cycles = 0;
    fifo_entry_t pop_q[$];
    logic [31:0] issue_q[$];
    int          grant_q[$];

    prefetch_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_address_i (req_address_i),
        .req_ready_o   (req_ready_o),
        .pf_valid_o    (pf_valid_o),
        .pf_address_o  (pf_address_o),
        .pf_ready_i    (pf_ready_i),
        .pf_address_i  (pf_address_i),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .mem_address_o (mem_address_o),
        .mem_id_o      (mem_id_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_pop(input string tag, input int k, input logic [1:0] id, input logic [31:0] addr);
        logic [63:0] obs;
        obs = (k < pop_q.size()) ? 64'(pop_q[k]) : {64{1'bx}};
        chk(tag, obs, 64'({id, addr}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pop_q.delete();
        issue_q.delete();
        grant_q.delete();
        busy_cycles = 0;
    endtask

    // Observers: memory pops, issue pulses, grants and busy cycles, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mem_valid_o && mem_ready_i) pop_q.push_back(fifo_entry_t'({mem_id_o, mem_address_o}));
                if (pf_valid_o) issue_q.push_back(pf_address_o);
                if (busy_o) busy_cycles++;
                for (int i = 0; i < 4; i++) begin
                    if (req_valid_i[i] && req_ready_o[i]) grant_q.push_back(i);
                end
            end
        end
    end

    // Prefetcher model: neighbours in order -x,+x,-y,+y,-z,+z, truncated to model_limit.
    initial begin
        logic [31:0] a;
        logic [31:0] nb [6];
        int n;
        pf_ready_i   = 1'b0;
        pf_address_i = '0;
        forever begin
            @(negedge clock);
            if (pf_valid_o === 1'b1) begin
                a = pf_address_o;
                n = 0;
                if (a[1:0] != 2'd0) begin nb[n] = a - 32'd1;  n = n + 1; end
                if (a[1:0] != 2'd3) begin nb[n] = a + 32'd1;  n = n + 1; end
                if (a[3:2] != 2'd0) begin nb[n] = a - 32'd4;  n = n + 1; end
                if (a[3:2] != 2'd3) begin nb[n] = a + 32'd4;  n = n + 1; end
                if (a[5:4] != 2'd0) begin nb[n] = a - 32'd16; n = n + 1; end
                if (a[5:4] != 2'd3) begin nb[n] = a + 32'd16; n = n + 1; end
                if (n > model_limit) n = model_limit;
                tick();
                tick();
                for (int k = 0; k < n; k++) begin
                    pf_ready_i   = 1'b1;
                    pf_address_i = nb[k];
                    tick();
                end
                pf_ready_i = 1'b0;
            end
        end
    end

    initial begin
        int rr_ids[18];
        rr_ids = '{0,0,0, 1,1,1,1,1,1, 2,2,2, 3,3,3, 0,0,0};
        reset = 1'b1;
        req_valid_i   = '0;
        req_address_i = '0;
        mem_ready_i   = 1'b0;
        tick();
        tick();
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready_o), 64'h0);
        chk("rst_pf_valid", 64'(pf_valid_o), 64'h0);
        chk("rst_pf_addr", 64'(pf_address_o), 64'h0);
        chk("rst_mem_valid", 64'(mem_valid_o), 64'h0);
        chk("rst_mem_addr", 64'(mem_address_o), 64'h0);
        chk("rst_mem_id", 64'(mem_id_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_timeout", 64'(timeout_o), 64'h0);
        chk("rst_drop", 64'(drop_cnt_o), 64'h0);
        do_reset();

        // Corner 0x00 from requester 0: three neighbours.
        mem_ready_i = 1'b1;
        tick();
        req_valid_i[0] = 1'b1; req_address_i[0] = 32'h00;
        @(negedge clock);
        chk("corner_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;
        @(negedge clock);
        chk("corner_pf_valid", 64'(pf_valid_o), 64'h1);
        chk("corner_pf_addr", 64'(pf_address_o), 64'h0);
        repeat (10) tick();
        chk("corner_issues", 64'(issue_q.size()), 64'd1);
        chk("corner_pops", 64'(pop_q.size()), 64'd3);
        chk_pop("corner_e0", 0, 2'd0, 32'h01);
        chk_pop("corner_e1", 1, 2'd0, 32'h04);
        chk_pop("corner_e2", 2, 2'd0, 32'h10);
        chk("corner_busy_cycles", 64'(busy_cycles), 64'd5);
        chk("corner_idle", 64'(busy_o), 64'h0);

        // Interior 0x15 from requester 1: six neighbours, busy for 8 cycles.
        pop_q.delete(); issue_q.delete(); busy_cycles = 0;
        req_valid_i[1] = 1'b1; req_address_i[1] = 32'h15;
        @(negedge clock);
        chk("int_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = '0;
        repeat (14) tick();
        chk("int_pops", 64'(pop_q.size()), 64'd6);
        chk_pop("int_e0", 0, 2'd1, 32'h14);
        chk_pop("int_e1", 1, 2'd1, 32'h16);
        chk_pop("int_e2", 2, 2'd1, 32'h11);
        chk_pop("int_e3", 3, 2'd1, 32'h19);
        chk_pop("int_e4", 4, 2'd1, 32'h05);
        chk_pop("int_e5", 5, 2'd1, 32'h25);
        chk("int_busy_cycles", 64'(busy_cycles), 64'd8);

        // Round-robin with all requesters continuously valid.
        do_reset();
        mem_ready_i = 1'b1;
        req_address_i[0] = 32'h00; req_address_i[1] = 32'h15;
        req_address_i[2] = 32'h03; req_address_i[3] = 32'h3F;
        req_valid_i = 4'hF;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant_q.size() >= 5) break;
        end
        req_valid_i = '0;
        chk("rr_grant_count", 64'(grant_q.size()), 64'd5);
        chk("rr_g0", 64'((grant_q.size() > 0) ? grant_q[0] : -1), 64'd0);
        chk("rr_g1", 64'((grant_q.size() > 1) ? grant_q[1] : -1), 64'd1);
        chk("rr_g2", 64'((grant_q.size() > 2) ? grant_q[2] : -1), 64'd2);
        chk("rr_g3", 64'((grant_q.size() > 3) ? grant_q[3] : -1), 64'd3);
        chk("rr_g4", 64'((grant_q.size() > 4) ? grant_q[4] : -1), 64'd0);
        repeat (14) tick();
        chk("rr_pops", 64'(pop_q.size()), 64'd18);
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("rr_id%0d", k), 64'((k < pop_q.size()) ? int'(pop_q[k].id) : -1), 64'(rr_ids[k]));
        end

        // Backpressure: memory stalled, admission waits for room for six.
        do_reset();
        mem_ready_i = 1'b0;
        tick();
        req_valid_i[0] = 1'b1; req_address_i[0] = 32'h00;
        @(negedge clock);
        chk("bp_a_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;
        repeat (8) tick();
        req_valid_i[1] = 1'b1; req_address_i[1] = 32'h03;
        @(negedge clock);
        chk("bp_free5_block", 64'(req_ready_o), 64'h0);
        tick();
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        @(negedge clock);
        chk("bp_b_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = '0;
        repeat (8) tick();
        req_valid_i[2] = 1'b1; req_address_i[2] = 32'h00;
        @(negedge clock);
        chk("bp_free3_block", 64'(req_ready_o), 64'h0);
        tick();
        mem_ready_i = 1'b1;
        tick();
        @(negedge clock);
        chk("bp_free4_block", 64'(req_ready_o), 64'h0);
        tick();
        @(negedge clock);
        chk("bp_free5_block2", 64'(req_ready_o), 64'h0);
        tick();
        mem_ready_i = 1'b0;
        @(negedge clock);
        chk("bp_c_ready", 64'(req_ready_o), 64'h4);
        tick();
        req_valid_i = '0;
        mem_ready_i = 1'b1;
        repeat (14) tick();
        chk("bp_pops", 64'(pop_q.size()), 64'd9);
        chk_pop("bp_e0", 0, 2'd0, 32'h01);
        chk_pop("bp_e2", 2, 2'd0, 32'h10);
        chk_pop("bp_e3", 3, 2'd1, 32'h02);
        chk_pop("bp_e4", 4, 2'd1, 32'h07);
        chk_pop("bp_e5", 5, 2'd1, 32'h13);
        chk_pop("bp_e6", 6, 2'd2, 32'h01);
        chk_pop("bp_e8", 8, 2'd2, 32'h10);

        // Out-of-range drop and saturation.
        do_reset();
        tick();
        req_valid_i[0] = 1'b1; req_address_i[0] = 32'h40;
        @(negedge clock);
        chk("oor_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;
        @(negedge clock);
        chk("oor_drop1", 64'(drop_cnt_o), 64'd1);
        chk("oor_no_issue", 64'(pf_valid_o), 64'h0);
        chk("oor_not_busy", 64'(busy_o), 64'h0);
        tick();
        req_valid_i[0] = 1'b1;
        repeat (253) @(posedge clock);
        #1;
        req_valid_i = '0;
        @(negedge clock);
        chk("oor_drop254", 64'(drop_cnt_o), 64'd254);
        tick();
        req_valid_i[0] = 1'b1;
        repeat (46) @(posedge clock);
        #1;
        req_valid_i = '0;
        @(negedge clock);
        chk("oor_drop_sat", 64'(drop_cnt_o), 64'd255);
        chk("oor_issue_count", 64'(issue_q.size()), 64'd0);

        // Timeout: model delivers 2 of 3 neighbours for 0x00.
        do_reset();
        model_limit = 2;
        mem_ready_i = 1'b1;
        tick();
        req_valid_i[0] = 1'b1; req_address_i[0] = 32'h00;
        @(negedge clock);
        chk("to_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;
        repeat (16) tick();
        @(negedge clock);
        chk("to_before", 64'(timeout_o), 64'h0);
        chk("to_busy_before", 64'(busy_o), 64'h1);
        tick();
        @(negedge clock);
        chk("to_set", 64'(timeout_o), 64'h1);
        chk("to_idle", 64'(busy_o), 64'h0);
        chk("to_pops", 64'(pop_q.size()), 64'd2);
        chk_pop("to_e0", 0, 2'd0, 32'h01);
        chk_pop("to_e1", 1, 2'd0, 32'h04);
        model_limit = 6;
        tick();
        req_valid_i[1] = 1'b1; req_address_i[1] = 32'h15;
        tick();
        req_valid_i = '0;
        repeat (14) tick();
        chk("to_sticky", 64'(timeout_o), 64'h1);
        chk("to_after_pops", 64'(pop_q.size()), 64'd8);

        // Reset asserted in the middle of a collect burst.
        do_reset();
        mem_ready_i = 1'b0;
        tick();
        req_valid_i[3] = 1'b1; req_address_i[3] = 32'h15;
        @(negedge clock);
        chk("mid_ready", 64'(req_ready_o), 64'h8);
        tick();
        req_valid_i = '0;
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clock);
        chk("mid_pre_valid", 64'(mem_valid_o), 64'h1);
        chk("mid_pre_id", 64'(mem_id_o), 64'h3);
        chk("mid_pre_addr", 64'(mem_address_o), 64'h14);
        chk("mid_pre_busy", 64'(busy_o), 64'h1);
        tick();
        @(negedge clock);
        chk("mid_rst_pf_valid", 64'(pf_valid_o), 64'h0);
        chk("mid_rst_pf_addr", 64'(pf_address_o), 64'h0);
        chk("mid_rst_mem_valid", 64'(mem_valid_o), 64'h0);
        chk("mid_rst_mem_addr", 64'(mem_address_o), 64'h0);
        chk("mid_rst_mem_id", 64'(mem_id_o), 64'h0);
        chk("mid_rst_busy", 64'(busy_o), 64'h0);
        chk("mid_rst_timeout", 64'(timeout_o), 64'h0);
        chk("mid_rst_drop", 64'(drop_cnt_o), 64'h0);
        reset = 1'b0;
        repeat (10) tick();
        @(negedge clock);
        chk("mid_after_empty", 64'(mem_valid_o), 64'h0);
        chk("mid_after_idle", 64'(busy_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
